// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: default word width,
// stall counter width and the payload structs carried between stages.
package pipe_pkg;

  localparam int WORD_W      = 32;
  localparam int STALL_CNT_W = 16;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] rs_val;
    logic [WORD_W-1:0] rt_val;
    logic [WORD_W-1:0] imm;
    logic [4:0]        rd;
  } id_ex_t;

  typedef struct packed {
    logic [WORD_W-1:0] alu_res;
    logic [WORD_W-1:0] st_data;
    logic [4:0]        rd;
    logic              mem_rd;
    logic              mem_wr;
  } ex_mem_t;

  typedef struct packed {
    logic [WORD_W-1:0] wb_data;
    logic [4:0]        rd;
    logic              reg_wr;
  } mem_wb_t;

endpackage

// File: rtl/pipe_skid_slot.sv
// One pipeline slot: a main entry driving the output plus a one-entry skid buffer,
// so the upstream ready is a flop (!skid_v) and never a path from out_ready.
module pipe_skid_slot
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = WORD_W,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       vld_cnt
);

  logic             main_v;
  logic [WIDTH-1:0] main_d;
  logic             skid_v;
  logic [WIDTH-1:0] skid_d;
  logic             accept;
  logic             emit;

  assign in_ready  = !skid_v;
  assign out_valid = main_v;
  assign out_data  = main_d;
  assign accept    = in_valid && !skid_v;
  assign emit      = main_v && out_ready;
  assign vld_cnt   = {1'b0, main_v} + {1'b0, skid_v};

  // Flush drops valids only; data is left as-is since nothing reads it while invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_v <= 1'b0;
      main_d <= RESET_VAL;
      skid_v <= 1'b0;
      skid_d <= RESET_VAL;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (!main_v || emit) begin
      if (skid_v) begin
        main_v <= 1'b1;
        main_d <= skid_d;
        skid_v <= 1'b0;
      end else begin
        main_v <= accept;
        if (accept) main_d <= in_data;
      end
    end else if (accept) begin
      skid_v <= 1'b1;
      skid_d <= in_data;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Chain of DEPTH skid-buffered slots with flush and occupancy reporting.
// Optional stall counter output enabled by defining PIPE_SKID_STALL_CNT_EN.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = WORD_W,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              OCC_W     = $clog2(2*DEPTH+1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
`ifdef PIPE_SKID_STALL_CNT_EN
  output logic [STALL_CNT_W-1:0] stall_cnt,
`endif
  output logic [OCC_W-1:0]       occupancy
);

  // Index k is the link feeding slot k; index DEPTH is the chain output.
  logic [DEPTH:0]   lnk_v;
  logic [DEPTH:0]   lnk_r;
  logic [WIDTH-1:0] lnk_d [0:DEPTH];
  logic [1:0]       slot_cnt [0:DEPTH-1];
  logic [OCC_W-1:0] occ_sum;

  assign lnk_v[0]     = in_valid;
  assign lnk_d[0]     = in_data;
  assign in_ready     = lnk_r[0];
  assign lnk_r[DEPTH] = out_ready;
  assign out_valid    = lnk_v[DEPTH];
  assign out_data     = lnk_d[DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    pipe_skid_slot #(
      .WIDTH    (WIDTH),
      .RESET_VAL(RESET_VAL)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .in_valid (lnk_v[k]),
      .in_ready (lnk_r[k]),
      .in_data  (lnk_d[k]),
      .out_valid(lnk_v[k+1]),
      .out_ready(lnk_r[k+1]),
      .out_data (lnk_d[k+1]),
      .vld_cnt  (slot_cnt[k])
    );
  end

  // Sum of flop outputs only, so it tracks the valid bits with no extra lag.
  always_comb begin
    occ_sum = '0;
    for (int k = 0; k < DEPTH; k++) occ_sum = occ_sum + OCC_W'(slot_cnt[k]);
  end

  assign occupancy = occ_sum;

`ifdef PIPE_SKID_STALL_CNT_EN
  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] x);
    return (&x) ? x : x + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         stall_cnt <= '0;
    else if (flush)                  stall_cnt <= '0;
    else if (out_valid && !out_ready) stall_cnt <= sat_inc(stall_cnt);
  end
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: three chain depths share the stimulus, a
// scoreboard follows the instance selected by sel. Define PIPE_SKID_STALL_CNT_EN to cover stall_cnt.
module tb_pipe_skid_reg;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, out_ready;
  logic [W-1:0] in_data;

  logic ir1, ov1, ir2, ov2, ir3, ov3;
  logic [W-1:0] od1, od2, od3;
  logic [1:0] oc1;
  logic [2:0] oc2, oc3;
`ifdef PIPE_SKID_STALL_CNT_EN
  logic [15:0] sc1, sc2, sc3;
`endif

  always #5 clk = ~clk;

  pipe_skid_reg #(.WIDTH(W), .DEPTH(1), .RESET_VAL(8'h00)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
    .in_data(in_data), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
`ifdef PIPE_SKID_STALL_CNT_EN
    .stall_cnt(sc1),
`endif
    .occupancy(oc1));

  pipe_skid_reg #(.WIDTH(W), .DEPTH(2), .RESET_VAL(8'h00)) u2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir2),
    .in_data(in_data), .out_valid(ov2), .out_ready(out_ready), .out_data(od2),
`ifdef PIPE_SKID_STALL_CNT_EN
    .stall_cnt(sc2),
`endif
    .occupancy(oc2));

  pipe_skid_reg #(.WIDTH(W), .DEPTH(3), .RESET_VAL(8'h00)) u3 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir3),
    .in_data(in_data), .out_valid(ov3), .out_ready(out_ready), .out_data(od3),
`ifdef PIPE_SKID_STALL_CNT_EN
    .stall_cnt(sc3),
`endif
    .occupancy(oc3));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int sel = 2;
  int n_emit = 0;
  int first_emit = -1;
  int last_emit = -1;
  logic [W-1:0] q[$];

  logic         s_ir, s_ov;
  logic [W-1:0] s_od;
  logic [3:0]   s_oc;

  always_comb begin
    s_ir = ir2; s_ov = ov2; s_od = od2; s_oc = {1'b0, oc2};
    case (sel)
      1: begin s_ir = ir1; s_ov = ov1; s_od = od1; s_oc = {2'b00, oc1}; end
      3: begin s_ir = ir3; s_ov = ov3; s_od = od3; s_oc = {1'b0, oc3}; end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clean();
    in_valid = 1'b0;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
  endtask

  task automatic clr_emit();
    n_emit = 0;
    first_emit = -1;
    last_emit = -1;
  endtask

  // Scoreboard: handshakes are stable mid-cycle and take effect at the next edge.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      if (s_ov && out_ready) begin
        if (first_emit < 0) first_emit = cyc;
        last_emit = cyc;
        n_emit++;
        checks++;
        assert (q.size() != 0) else begin
          errors++;
          $error("FAIL sb_extra_item observed=%0h expected=none", s_od);
        end
        if (q.size() != 0) chk("sb_data", 32'(s_od), 32'(q.pop_front()));
      end
      if (in_valid && s_ir && !flush) q.push_back(in_data);
      if (flush) q.delete();
    end
  end

  initial begin
    int lat;
    int c0;
    int idx;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
    #1;
    chk("rst_out_valid", 32'(ov2), 0);
    chk("rst_in_ready", 32'(ir2), 1);
    chk("rst_occupancy", 32'(oc2), 0);
    step();
    rst = 1'b0;
    step();

    // Reset mid-stream on DEPTH=2
    sel = 2;
    in_valid = 1'b1; in_data = 8'h10; step();
    in_data = 8'h11; step();
    #1 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(ov2), 0);
    chk("midrst_out_data", 32'(od2), 0);
    chk("midrst_in_ready", 32'(ir2), 1);
    chk("midrst_occupancy", 32'(oc2), 0);
    in_valid = 1'b0;
    step();
    rst = 1'b0;
    clr_emit();
    repeat (6) step();
    chk("midrst_no_output", 32'(n_emit), 0);

    // Streaming on DEPTH=3
    sel = 3;
    clean();
    clr_emit();
    out_ready = 1'b1;
    lat = -1;
    c0 = cyc;
    for (int i = 1; i <= 20; i++) begin
      in_valid = 1'b1;
      in_data  = W'(i);
      chk("stream_in_ready", 32'(ir3), 1);
      step();
      if (ov3 && lat < 0) lat = cyc - c0;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (ov3 && lat < 0) lat = cyc - c0;
    end
    chk("stream_latency", 32'(lat), 3);
    chk("stream_count", 32'(n_emit), 20);
    chk("stream_no_gaps", 32'(last_emit - first_emit), 19);
    chk("stream_sb_empty", 32'(q.size()), 0);

    // Backpressure on DEPTH=2
    sel = 2;
    clean();
    clr_emit();
    out_ready = 1'b0;
    idx = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = (idx < 8);
      in_data  = 8'hA0 + W'(idx);
      c0 = int'(in_valid && ir2);
      step();
      idx += c0;
    end
    in_valid = 1'b0;
    chk("bp_accepted", 32'(idx), 4);
    chk("bp_in_ready", 32'(ir2), 0);
    chk("bp_occupancy", 32'(oc2), 4);
    chk("bp_out_valid", 32'(ov2), 1);
    chk("bp_out_data", 32'(od2), 32'h A0);
    step();
    chk("bp_out_data_stable", 32'(od2), 32'h A0);
    out_ready = 1'b1;
    repeat (8) step();
    chk("bp_drain_count", 32'(n_emit), 4);
    chk("bp_drain_no_gaps", 32'(last_emit - first_emit), 3);
    chk("bp_drain_occupancy", 32'(oc2), 0);

    // Flush with two held items on DEPTH=1
    sel = 1;
    clean();
    clr_emit();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h30; step();
    in_data = 8'h31; step();
    chk("fl_full_occupancy", 32'(oc1), 2);
    flush = 1'b1; in_data = 8'h55;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", 32'(ov1), 0);
    chk("fl_occupancy", 32'(oc1), 0);
    out_ready = 1'b1;
    repeat (4) step();
    chk("fl_nothing_emitted", 32'(n_emit), 0);

    // Flush dropping an accept that the slot was ready for
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h40; step();
    chk("fl2_in_ready", 32'(ir1), 1);
    flush = 1'b1; in_data = 8'h56;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl2_out_valid", 32'(ov1), 0);
    chk("fl2_occupancy", 32'(oc1), 0);
    out_ready = 1'b1;
    repeat (4) step();
    chk("fl2_nothing_emitted", 32'(n_emit), 0);

    // Simultaneous accept and emit on DEPTH=1
    clean();
    clr_emit();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h06; step();
    in_data = 8'h07; out_ready = 1'b1;
    chk("ae_in_ready", 32'(ir1), 1);
    step();
    in_valid = 1'b0;
    chk("ae_out_data", 32'(od1), 7);
    chk("ae_out_valid", 32'(ov1), 1);
    chk("ae_occupancy", 32'(oc1), 1);
    repeat (3) step();
    chk("ae_emitted", 32'(n_emit), 2);
    chk("ae_sb_empty", 32'(q.size()), 0);

`ifdef PIPE_SKID_STALL_CNT_EN
    clean();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h09; step();
    in_valid = 1'b0;
    repeat (5) step();
    chk("sc_five", 32'(sc1), 5);
    flush = 1'b1; step(); flush = 1'b0;
    chk("sc_flush", 32'(sc1), 0);
    in_valid = 1'b1; in_data = 8'h0A; step();
    in_valid = 1'b0;
    repeat (70000) @(posedge clk);
    #1;
    chk("sc_saturate", 32'(sc1), 32'h FFFF);
    clean();
    out_ready = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
